// File: rtl/serial_compare_ctrl_if.sv
// serial_compare_ctrl_if
//   Request/result bundle between a requesting datapath (master) and the
//   bit-serial compare controller (slave).
//   start       : request strobe, honoured only while busy=0
//   a, b        : unsigned WIDTH-bit operands, captured on the accepting edge
//   busy        : controller is stepping through the operand bits
//   done        : one-cycle pulse, result valid from this cycle on
//   gt, lt, eq  : held comparison result (A>B, A<B, A==B)
interface serial_compare_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             gt;
  logic             lt;
  logic             eq;

  modport master (
    output start, a, b,
    input  busy, done, gt, lt, eq
  );

  modport slave (
    input  start, a, b,
    output busy, done, gt, lt, eq
  );
endinterface

// File: rtl/serial_compare_ctrl.sv
// serial_compare_ctrl
//   Bit-serial unsigned magnitude comparator. A single 1-bit comparator
//   slice is stepped MSB-first, one bit per clock; its sticky p ("greater
//   decided") / q ("less decided") chain state lives in flops between cycles.
//
//   Ports
//     clk    : system clock, rising-edge
//     reset  : asynchronous, active-low reset
//     bus    : serial_compare_ctrl_if.slave (start, a, b, busy, done, gt, lt, eq)
//
//   Optional feature macro: SERIAL_CMP_EARLY_EXIT_EN
//     Defined   : RUN ends as soon as the slice has decided (p|q), so latency
//                 is (leading equal bits)+2 cycles, capped at WIDTH+1.
//     Undefined : fixed WIDTH+1 cycle latency.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for start
//   RUN    | feeding bit cnt of A/B to the slice, busy=1
//   DONE   | one-cycle done pulse; start here is accepted back-to-back
module serial_compare_ctrl #(
  parameter int WIDTH = 32,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  serial_compare_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [CW-1:0]    r_cnt;
  logic             r_p;
  logic             r_q;
  logic             r_gt;
  logic             r_lt;
  logic             r_eq;

  logic             w_accept;
  logic             w_busy;
  logic             w_done;
  logic             w_abit;
  logic             w_bbit;
  logic             w_pout;
  logic             w_qout;
  logic             w_last;

  // Comparator slice; p/q stay set once decided, and the controller only
  // ever presents p=q=0 or exactly one of them set.
  assign w_abit = r_a[r_cnt];
  assign w_bbit = r_b[r_cnt];
  assign w_pout = r_p | (~r_p & ~r_q &  w_abit & ~w_bbit);
  assign w_qout = r_q | (~r_p & ~r_q & ~w_abit &  w_bbit);

`ifdef SERIAL_CMP_EARLY_EXIT_EN
  // Once any bit differs the remaining lower bits cannot change the outcome.
  assign w_last = (r_cnt == '0) | w_pout | w_qout;
`else
  assign w_last = (r_cnt == '0);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_busy   = 1'b0;
    w_done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_accept = 1'b1;
          w_next   = S_RUN;
        end
      end
      S_RUN: begin
        w_busy = 1'b1;
        if (w_last) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        w_done = 1'b1;
        if (bus.start) begin
          w_accept = 1'b1;
          w_next   = S_RUN;
        end else begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_a   <= '0;
      r_b   <= '0;
      r_cnt <= '0;
      r_p   <= 1'b0;
      r_q   <= 1'b0;
      r_gt  <= 1'b0;
      r_lt  <= 1'b0;
      r_eq  <= 1'b0;
    end else if (w_accept) begin
      r_a   <= bus.a;
      r_b   <= bus.b;
      r_p   <= 1'b0;
      r_q   <= 1'b0;
      r_cnt <= CW'(WIDTH - 1);
    end else if (r_state == S_RUN) begin
      r_p <= w_pout;
      r_q <= w_qout;
      if (w_last) begin
        // Result is taken from the slice outputs being registered on this
        // edge, so it is already valid in the DONE cycle.
        r_gt <= w_pout;
        r_lt <= w_qout;
        r_eq <= ~w_pout & ~w_qout;
      end else begin
        r_cnt <= r_cnt - CW'(1);
      end
    end
  end

  assign bus.busy = w_busy;
  assign bus.done = w_done;
  assign bus.gt   = r_gt;
  assign bus.lt   = r_lt;
  assign bus.eq   = r_eq;

endmodule
